// File: rtl/spart_pkg.sv
// Shared SPART definitions: FSM state encoding and default baud/FIFO constants
// used by both the transmit and receive sides.
package spart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } spart_state_e;

    localparam int unsigned SPART_DIV_DEFAULT   = 434;
    localparam int unsigned SPART_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/spart_tx_if.sv
// Processor-side write port of the SPART transmitter: byte strobe plus back-pressure.
interface spart_tx_if;

    logic       send;
    logic [7:0] send_data;
    logic       full;

    modport master (output send, output send_data, input full);
    modport slave  (input send, input send_data, output full);

endinterface

// File: rtl/spart_tx_fifo.sv
// Transmit FIFO: power-of-two ring buffer with registered occupancy; full/empty
// are decoded only from registered state.
module spart_tx_fifo
    import spart_pkg::*;
#(
    parameter int unsigned DEPTH = SPART_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop cancel out in the occupancy count.
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: FIFO-buffered 8N1 serializer with a DIV-cycle bit timer.
// Frames run back-to-back when the FIFO has data at the end of STOP.
module spart_tx
    import spart_pkg::*;
#(
    parameter int unsigned DIV   = SPART_DIV_DEFAULT,
    parameter int unsigned DEPTH = SPART_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    spart_tx_if.slave  bus,
    output logic       txd,
    output logic       tx_busy
);

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    spart_state_e state_q, state_d;
    logic [7:0]   shreg_q, shreg_d;
    logic [2:0]   bit_q, bit_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         txd_q, txd_d;
    logic         pop;
    logic [7:0]   head;
    logic         empty;

    spart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.send),
        .pop   (pop),
        .din   (bus.send_data),
        .dout  (head),
        .full  (bus.full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    state_d = ST_START;
                    cnt_d   = DIV_M1;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = DIV_M1;
                    bit_d   = '0;
                    txd_d   = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = DIV_M1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Shift first so shreg_q[0] is always the bit on the line.
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        txd_d   = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = head;
                        state_d = ST_START;
                        cnt_d   = DIV_M1;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = (state_q != ST_IDLE) || !empty;

endmodule
